req_ack_fifo: RTL and testbench
===============================

# req_ack_fifo

Synchronous single-clock FIFO that serves as the slave endpoint of both `fifo_push_if` and `fifo_pop_if`. It accepts entries through a push req/ack handshake and returns them in order through a pop req/ack handshake. Each side runs independently in either handshake mode or stream mode. It sits between AXI burst producers and consumers and buffers beats and commands.

## Interface
Parameters:
- `T`, default `logic [63:0]`: entry data type.
- `DEPTH`, default 16: number of entries; must be a power of two, minimum 2.

Ports. One clock; reset is asynchronous and active-low. Clock is `clk`, reset is `rstn`.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `push` slave modport of `fifo_push_if`:
  - `req` in 1
  - `data_in` in `T`
  - `ack` out 1
  - `ack_pulse` out 1
  - `fifo_full` out 1
- `push_stream_mode` in 1: push side mode; 0 = handshake, 1 = stream. Driven from the interface's `stream_mode`.
- `pop` slave modport of `fifo_pop_if`:
  - `req` in 1
  - `data_out` out `T`
  - `ack` out 1
  - `ack_pulse` out 1
  - `fifo_empty` out 1
- `pop_stream_mode` in 1: pop side mode; 0 = handshake, 1 = stream.

## Operation
Storage and flags:
- Circular buffer of `DEPTH` entries with `wr_ptr`, `rd_ptr` (`$clog2(DEPTH)` bits, natural wrap) and `count` (`$clog2(DEPTH)+1` bits).
- `fifo_full` = (`count`==`DEPTH`); `fifo_empty` = (`count`==0). Both are registered from `count`.

Push, handshake mode (0):
- Accept when `req` && !`fifo_full` && !`ack`.
- On accept: write `data_in`, advance `wr_ptr`, register `ack`=1 for exactly one cycle.
- Master drops `req` on seeing `ack`. Because `ack` is high in the cycle after accept, no entry is written twice.
- Peak rate: one entry per 2 cycles.

Push, stream mode (1):
- `ack` = `req` && !`fifo_full`, combinational.
- An entry is written at every rising edge where `ack`=1, so throughput is one entry per cycle.

Pop, handshake mode (0):
- Accept when `req` && !`fifo_empty` && !`ack`.
- On accept: register `data_out` = `mem[rd_ptr]`, advance `rd_ptr`, register `ack`=1 for one cycle.
- `data_out` holds its value until the next accepted pop.

Pop, stream mode (1):
- `data_out` = `mem[rd_ptr]`, first-word fall-through, combinational; it is 0 when empty.
- `ack` = `req` && !`fifo_empty`, combinational.
- `rd_ptr` advances at every rising edge where `ack`=1.

`ack_pulse`: one cycle high per accepted transfer.
- Mode 0: identical to `ack`.
- Mode 1: high in each cycle whose edge performs a transfer.

Boundary conditions:
- Push while full: no write, `ack` stays low, master waits.
- Pop while empty: no read, `ack` stays low, `data_out` unchanged (mode 0) or 0 (mode 1).
- Simultaneous push and pop: both are performed and `count` is unchanged.
- Push is gated by the current `fifo_full` even when a pop completes in the same cycle. Pop is likewise gated by `fifo_empty`.
- Stream mode inputs must only change while the corresponding `req` is low. Behaviour under a mid-transfer mode change is unspecified.
- Reset mid-operation: all state clears immediately; in-flight transfers are discarded; masters abort their tasks.

## Timing
Reset values:
- `ack`, `ack_pulse`: 0 on both sides.
- `fifo_full` = 0, `fifo_empty` = 1.
- `data_out` = 0.
- Pointers and `count`: 0.
- Memory contents are not reset.

Latency and flags:
- Mode 0: `ack` rises 1 cycle after the first edge that samples `req` high.
- Mode 1: `ack` follows `req` in the same cycle.
- Write-to-visible: an entry pushed at edge N makes `fifo_empty` fall after edge N, so it can be popped from edge N+1.
- `fifo_full` asserts after the edge that writes the `DEPTH`-th entry and deasserts after the edge of a pop.

## Structure
- Shared package `fifo_pkg` holds:
  - the default entry typedef `fifo_data_t` (`logic [63:0]`);
  - the `DEFAULT_FIFO_DEPTH` constant;
  - the mode encoding enum `fifo_mode_e` {`HANDSHAKE`=0, `STREAM`=1}.
- One sub-module, `fifo_mem`: a `DEPTH`×`T` register array with synchronous write and asynchronous read by index. Pointers, count and both handshake FSMs stay in `req_ack_fifo`.

## Test plan
- Reset with `rstn`=0 → `fifo_empty`=1, `fifo_full`=0, both acks 0, `data_out`=0.
- Handshake push of 0x11, 0x22, 0x33, then handshake pop of 3 → `data_out` sequence 0x11, 0x22, 0x33; each `ack` exactly 1 cycle wide; `fifo_empty`=1 at the end.
- Stream push of 16 entries 0..15 with `DEPTH`=16 → 16 consecutive `ack` cycles; `fifo_full`=1; a 17th `req` is not acked until one stream pop occurs.
- Stream pop of 16 → `data_out` 0..15 on consecutive cycles; ack drops the cycle `fifo_empty` rises; pointer wrap verified by a second fill of 16..31 popping in order.
- Simultaneous stream push and pop at `count`=5 for 10 cycles → `count` stays 5; FIFO order is preserved.
- `rstn` pulsed low during a 10-entry stream push after 4 entries → all acks 0 immediately; after release `fifo_empty`=1 and the old data is unreadable.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO types: default entry type, default depth and side mode encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_pkg;

    typedef logic [63:0] fifo_data_t;

    localparam int DEFAULT_FIFO_DEPTH = 16;

    typedef enum logic {
        HANDSHAKE = 1'b0,
        STREAM    = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_pop_if.sv
// Pop-side req/ack bundle between a consumer (master) and the FIFO (slave).
// Latency: n/a (signal bundle only).
// Backpressure: consumer holds req until ack; fifo_empty reports nothing to read.
// Ports (slave view): req in; data_out, ack, ack_pulse, fifo_empty out.
interface fifo_pop_if #(
    parameter type T = fifo_pkg::fifo_data_t
) ();

    logic req;
    T     data_out;
    logic ack;
    logic ack_pulse;
    logic fifo_empty;
    logic stream_mode;

    modport slave (
        input  req,
        output data_out,
        output ack,
        output ack_pulse,
        output fifo_empty
    );

    modport master (
        output req,
        output stream_mode,
        input  data_out,
        input  ack,
        input  ack_pulse,
        input  fifo_empty
    );

endinterface

// File: rtl/fifo_push_if.sv
// Push-side req/ack bundle between a producer (master) and the FIFO (slave).
// Latency: n/a (signal bundle only).
// Backpressure: producer holds req/data_in until ack; fifo_full reports no space.
// Ports (slave view): req, data_in in; ack, ack_pulse, fifo_full out.
interface fifo_push_if #(
    parameter type T = fifo_pkg::fifo_data_t
) ();

    logic req;
    T     data_in;
    logic ack;
    logic ack_pulse;
    logic fifo_full;
    logic stream_mode;

    modport slave (
        input  req,
        input  data_in,
        output ack,
        output ack_pulse,
        output fifo_full
    );

    modport master (
        output req,
        output data_in,
        output stream_mode,
        input  ack,
        input  ack_pulse,
        input  fifo_full
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x T register array: synchronous write, asynchronous read by index.
// Latency: write visible after the clock edge; read is combinational.
// Backpressure: none; the caller gates wr_en.
// Ports: clk; wr_en/wr_idx/wr_dat write port; rd_idx in, rd_dat out.
module fifo_mem #(
    parameter type T     = fifo_pkg::fifo_data_t,
    parameter int  DEPTH = fifo_pkg::DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  T                         wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output T                         rd_dat
);

    // Storage is deliberately left out of reset; pointers and count define validity.
    T mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/req_ack_fifo.sv
// Single-clock FIFO, slave on both push and pop sides; each side handshake or stream mode.
// Latency: handshake ack 1 cycle after req sampled, stream ack same cycle; write-to-pop 1 edge.
// Backpressure: push held off while fifo_full, pop held off while fifo_empty (registered flags).
// Ports: clk, rstn (async active-low); push slave modport + push_stream_mode;
//        pop slave modport + pop_stream_mode. Interface T must match module T.
module req_ack_fifo
    import fifo_pkg::*;
#(
    parameter type T     = fifo_data_t,
    parameter int  DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    fifo_push_if.slave  push,
    input  logic        push_stream_mode,
    fifo_pop_if.slave   pop,
    input  logic        pop_stream_mode
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ack_q, push_ack_d;
    logic          pop_ack_q, pop_ack_d;
    T              dout_q, dout_d;

    T              mem_rd_dat;
    fifo_mode_e    push_mode;
    fifo_mode_e    pop_mode;
    logic          push_fire;
    logic          pop_fire;

    assign push_mode = fifo_mode_e'(push_stream_mode);
    assign pop_mode  = fifo_mode_e'(pop_stream_mode);

    // Handshake sides refuse a new transfer while their own ack is high, giving
    // the master the ack cycle to drop req so nothing is transferred twice.
    // rstn gates the fire terms so stream acks drop the moment reset asserts
    // and no write lands in the unreset memory during reset.
    assign push_fire = rstn && push.req && !full_q
                       && ((push_mode == STREAM) || !push_ack_q);
    assign pop_fire  = rstn && pop.req && !empty_q
                       && ((pop_mode == STREAM) || !pop_ack_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        push_ack_d = 1'b0;
        pop_ack_d  = 1'b0;

        if (push_fire) begin
            wr_ptr_d   = wr_ptr_q + AW'(1);
            push_ack_d = (push_mode == HANDSHAKE);
        end

        if (pop_fire) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            pop_ack_d = (pop_mode == HANDSHAKE);
            if (pop_mode == HANDSHAKE) begin
                dout_d = mem_rd_dat;
            end
        end

        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Flags are registered from the next count so they settle right after the edge.
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            push_ack_q <= 1'b0;
            pop_ack_q  <= 1'b0;
            dout_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            push_ack_q <= push_ack_d;
            pop_ack_q  <= pop_ack_d;
            dout_q     <= dout_d;
        end
    end

    fifo_mem #(
        .T     (T),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push_fire),
        .wr_idx (wr_ptr_q),
        .wr_dat (push.data_in),
        .rd_idx (rd_ptr_q),
        .rd_dat (mem_rd_dat)
    );

    // In stream mode ack is the transfer itself; in handshake mode it is the
    // registered one-cycle pulse. Either way ack_pulse marks one cycle per transfer.
    assign push.ack       = (push_mode == STREAM) ? push_fire : push_ack_q;
    assign push.ack_pulse = push.ack;
    assign push.fifo_full = full_q;

    // Stream pop is first-word fall-through and reads as zero while empty.
    assign pop.data_out   = (pop_mode == STREAM) ? (empty_q ? T'('0) : mem_rd_dat) : dout_q;
    assign pop.ack        = (pop_mode == STREAM) ? pop_fire : pop_ack_q;
    assign pop.ack_pulse  = pop.ack;
    assign pop.fifo_empty = empty_q;

endmodule

// File: tb/tb_req_ack_fifo.sv
// Directed bench for req_ack_fifo (DEPTH=16): handshake and stream traffic,
// full/empty gating, pointer wrap, concurrent push/pop and mid-burst reset.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_req_ack_fifo;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rstn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_push_if push_if ();
    fifo_pop_if  pop_if ();

    req_ack_fifo #(
        .T     (fifo_data_t),
        .DEPTH (16)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .push             (push_if),
        .push_stream_mode (push_if.stream_mode),
        .pop              (pop_if),
        .pop_stream_mode  (pop_if.stream_mode)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    // Handshake push; entered and left 1ns after a rising edge.
    task automatic push_hs(input logic [63:0] d);
        int n;
        push_if.req     = 1'b1;
        push_if.data_in = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!push_if.ack && n < 20);
        chk("push_hs_ack_latency", 64'(n), 64'd2);
        chk("push_hs_ack_pulse", 64'(push_if.ack_pulse), 64'd1);
        drive_point();
        push_if.req = 1'b0;
        @(negedge clk);
        chk("push_hs_ack_width", 64'(push_if.ack), 64'd0);
        drive_point();
    endtask

    // Handshake pop; entered and left 1ns after a rising edge.
    task automatic pop_hs(input logic [63:0] exp);
        int n;
        pop_if.req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pop_if.ack && n < 20);
        chk("pop_hs_ack_latency", 64'(n), 64'd2);
        chk("pop_hs_data", pop_if.data_out, exp);
        drive_point();
        pop_if.req = 1'b0;
        @(negedge clk);
        chk("pop_hs_ack_width", 64'(pop_if.ack), 64'd0);
        chk("pop_hs_data_hold", pop_if.data_out, exp);
        drive_point();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn                = 1'b0;
        push_if.req         = 1'b0;
        push_if.data_in     = '0;
        push_if.stream_mode = 1'b0;
        pop_if.req          = 1'b0;
        pop_if.stream_mode  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", 64'(pop_if.fifo_empty), 64'd1);
        chk("rst_full", 64'(push_if.fifo_full), 64'd0);
        chk("rst_push_ack", 64'(push_if.ack), 64'd0);
        chk("rst_pop_ack", 64'(pop_if.ack), 64'd0);
        chk("rst_pulses", 64'({push_if.ack_pulse, pop_if.ack_pulse}), 64'd0);
        chk("rst_data_out", pop_if.data_out, 64'd0);
        drive_point();
        rstn = 1'b1;

        // Handshake push then pop of three entries
        push_hs(64'h11);
        push_hs(64'h22);
        push_hs(64'h33);
        @(negedge clk);
        chk("hs_not_empty", 64'(pop_if.fifo_empty), 64'd0);
        chk("hs_not_full", 64'(push_if.fifo_full), 64'd0);
        drive_point();
        pop_hs(64'h11);
        pop_hs(64'h22);
        pop_hs(64'h33);
        @(negedge clk);
        chk("hs_empty_end", 64'(pop_if.fifo_empty), 64'd1);

        // Handshake pop on empty: no ack, data_out holds last value
        drive_point();
        pop_if.req = 1'b1;
        repeat (3) @(negedge clk);
        chk("hs_pop_empty_ack", 64'(pop_if.ack), 64'd0);
        chk("hs_pop_empty_hold", pop_if.data_out, 64'h33);
        drive_point();
        pop_if.req = 1'b0;

        // Switch both sides to stream mode while reqs are low
        drive_point();
        push_if.stream_mode = 1'b1;
        pop_if.stream_mode  = 1'b1;
        @(negedge clk);
        chk("st_empty_data_zero", pop_if.data_out, 64'd0);
        drive_point();

        // Stream fill of 16
        for (int i = 0; i < 16; i++) begin
            push_if.req     = 1'b1;
            push_if.data_in = 64'(i);
            @(negedge clk);
            chk("st_push_ack", 64'(push_if.ack), 64'd1);
            drive_point();
        end
        push_if.data_in = 64'd16;
        @(negedge clk);
        chk("st_full", 64'(push_if.fifo_full), 64'd1);
        chk("st_push_17_blocked", 64'(push_if.ack), 64'd0);
        drive_point();
        pop_if.req = 1'b1;
        @(negedge clk);
        chk("st_pop_at_full_ack", 64'(pop_if.ack), 64'd1);
        chk("st_pop_at_full_data", pop_if.data_out, 64'd0);
        chk("st_push_gated_by_full", 64'(push_if.ack), 64'd0);
        drive_point();
        pop_if.req = 1'b0;
        @(negedge clk);
        chk("st_push_17_ack", 64'(push_if.ack), 64'd1);
        chk("st_full_dropped", 64'(push_if.fifo_full), 64'd0);
        drive_point();
        push_if.req = 1'b0;
        @(negedge clk);
        chk("st_full_again", 64'(push_if.fifo_full), 64'd1);
        drive_point();

        // Stream drain of 16 (values 1..16)
        pop_if.req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("st_pop_ack", 64'(pop_if.ack), 64'd1);
            chk("st_pop_data", pop_if.data_out, 64'(i + 1));
            drive_point();
        end
        @(negedge clk);
        chk("st_drain_ack_drop", 64'(pop_if.ack), 64'd0);
        chk("st_drain_empty", 64'(pop_if.fifo_empty), 64'd1);
        chk("st_drain_data_zero", pop_if.data_out, 64'd0);
        drive_point();
        pop_if.req = 1'b0;

        // Second fill across the pointer wrap
        for (int i = 0; i < 16; i++) begin
            push_if.req     = 1'b1;
            push_if.data_in = 64'(100 + i);
            @(negedge clk);
            chk("wrap_push_ack", 64'(push_if.ack), 64'd1);
            drive_point();
        end
        push_if.req = 1'b0;
        @(negedge clk);
        chk("wrap_full", 64'(push_if.fifo_full), 64'd1);
        drive_point();
        pop_if.req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("wrap_pop_data", pop_if.data_out, 64'(100 + i));
            drive_point();
        end
        pop_if.req = 1'b0;
        @(negedge clk);
        chk("wrap_empty", 64'(pop_if.fifo_empty), 64'd1);
        drive_point();

        // Concurrent stream push and pop at count 5
        for (int i = 0; i < 5; i++) begin
            push_if.req     = 1'b1;
            push_if.data_in = 64'(200 + i);
            drive_point();
        end
        for (int k = 0; k < 10; k++) begin
            push_if.req     = 1'b1;
            push_if.data_in = 64'(205 + k);
            pop_if.req      = 1'b1;
            @(negedge clk);
            chk("sim_count", 64'(dut.count_q), 64'd5);
            chk("sim_pop_data", pop_if.data_out, 64'(200 + k));
            chk("sim_acks", 64'({push_if.ack, pop_if.ack}), 64'd3);
            drive_point();
        end
        push_if.req = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) chk("sim_count_after", 64'(dut.count_q), 64'd5);
            chk("sim_tail_data", pop_if.data_out, 64'(210 + j));
            drive_point();
        end
        pop_if.req = 1'b0;
        @(negedge clk);
        chk("sim_empty", 64'(pop_if.fifo_empty), 64'd1);
        drive_point();

        // Reset in the middle of a 10-entry stream burst, after 4 entries
        for (int i = 0; i < 4; i++) begin
            push_if.req     = 1'b1;
            push_if.data_in = 64'(300 + i);
            drive_point();
        end
        push_if.data_in = 64'd304;
        rstn = 1'b0;
        #1;
        chk("mid_rst_push_ack", 64'(push_if.ack), 64'd0);
        chk("mid_rst_pulses", 64'({push_if.ack_pulse, pop_if.ack_pulse}), 64'd0);
        chk("mid_rst_empty", 64'(pop_if.fifo_empty), 64'd1);
        chk("mid_rst_count", 64'(dut.count_q), 64'd0);
        drive_point();
        push_if.req = 1'b0;
        rstn        = 1'b1;
        pop_if.req  = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", 64'(pop_if.fifo_empty), 64'd1);
        chk("post_rst_pop_ack", 64'(pop_if.ack), 64'd0);
        chk("post_rst_data_zero", pop_if.data_out, 64'd0);
        drive_point();
        pop_if.req      = 1'b0;
        push_if.req     = 1'b1;
        push_if.data_in = 64'h55;
        drive_point();
        push_if.req = 1'b0;
        pop_if.req  = 1'b1;
        @(negedge clk);
        chk("post_rst_fresh_data", pop_if.data_out, 64'h55);
        chk("post_rst_fresh_ack", 64'(pop_if.ack), 64'd1);
        drive_point();
        pop_if.req = 1'b0;
        @(negedge clk);
        chk("post_rst_final_empty", 64'(pop_if.fifo_empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
